// File: rtl/fpsr_pkg.sv
// Shared definitions for the first-person-second-row game blocks.
// Holds the game state encoding, the game length and the LFSR feedback taps.
package fpsr_pkg;

    typedef enum logic [2:0] {
        ST_STOP         = 3'd0,
        ST_RUN          = 3'd1,
        ST_PROF_PENDING = 3'd2,
        ST_QUIZ         = 3'd3,
        ST_EXPIRED      = 3'd4
    } state_t;

    localparam int MAX_TIME = 120;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/game_clock_scheduler_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR with a nonzero seed; advances one step per enabled cycle.
// Output is the register itself, so a new value is visible the cycle after each step.
module lfsr8
    import fpsr_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_en,
    output logic [7:0] o_q
);

    logic [7:0] r_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q <= SEED;
        end else if (i_en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/game_clock_scheduler.sv
// Game minute counter, professor-visit scheduler and quiz window timer.
// All outputs are registered; a minute strobe updates minutes, tick_min and state on the next edge.
module game_clock_scheduler
    import fpsr_pkg::*;
#(
    parameter int         TICKS_PER_MIN = 100_000_000,
    parameter int         MAX_TIME      = fpsr_pkg::MAX_TIME,
    parameter int         QUIZ_WINDOW   = 3,
    parameter int         MIN_GAP       = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       pause,
    input  logic       quiz_active,
    output logic [7:0] minutes,
    output logic       tick_min,
    output logic       professor_req,
    output logic       quiz_timeout,
    output logic       time_up
);

    localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int QW = ($clog2(QUIZ_WINDOW + 1) > 2) ? $clog2(QUIZ_WINDOW + 1) : 2;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);
    localparam logic [7:0]    MAX_MIN    = 8'(MAX_TIME);
    localparam logic [QW-1:0] QLOAD      = QW'(QUIZ_WINDOW);
    localparam logic [4:0]    GAP_BASE   = 5'(MIN_GAP);

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [4:0]    r_gap;
    logic [QW-1:0] r_qcnt;
    logic [7:0]    r_minutes;
    logic          r_tick_min;
    logic          r_prof_req;
    logic          r_quiz_timeout;
    logic          r_time_up;

    logic [7:0] w_lfsr;
    logic       w_counting;
    logic       w_tick;
    logic [7:0] w_min_next;
    logic       w_expire;
    logic [4:0] w_gap_load;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .i_en  (1'b1),
        .o_q   (w_lfsr)
    );

    assign w_counting = (r_state == ST_RUN) || (r_state == ST_PROF_PENDING) ||
                        (r_state == ST_QUIZ);
    assign w_tick     = w_counting && !pause && (r_presc == PRESC_LAST);
    assign w_min_next = r_minutes + 8'd1;
    assign w_expire   = w_tick && (w_min_next == MAX_MIN);
    assign w_gap_load = GAP_BASE + {1'b0, w_lfsr[3:0]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= ST_STOP;
            r_presc        <= '0;
            r_gap          <= '0;
            r_qcnt         <= '0;
            r_minutes      <= '0;
            r_tick_min     <= 1'b0;
            r_prof_req     <= 1'b0;
            r_quiz_timeout <= 1'b0;
            r_time_up      <= 1'b0;
        end else begin
            r_tick_min     <= 1'b0;
            r_quiz_timeout <= 1'b0;
            if (Ack) begin
                r_state    <= ST_STOP;
                r_presc    <= '0;
                r_gap      <= '0;
                r_qcnt     <= '0;
                r_minutes  <= '0;
                r_prof_req <= 1'b0;
                r_time_up  <= 1'b0;
            end else begin
                // Holding the prescaler under pause delays the tick rather than dropping it
                if (w_counting && !pause) begin
                    r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
                end
                if (w_tick) begin
                    r_minutes  <= w_min_next;
                    r_tick_min <= 1'b1;
                end
                case (r_state)
                    ST_STOP: begin
                        if (Start) begin
                            r_state <= ST_RUN;
                            r_gap   <= w_gap_load;
                        end
                    end
                    ST_RUN: begin
                        if (w_expire) begin
                            r_state   <= ST_EXPIRED;
                            r_time_up <= 1'b1;
                        end else if (w_tick) begin
                            r_gap <= r_gap - 5'd1;
                            if (r_gap <= 5'd1) begin
                                r_state    <= ST_PROF_PENDING;
                                r_prof_req <= 1'b1;
                            end
                        end
                    end
                    ST_PROF_PENDING: begin
                        if (w_expire) begin
                            r_state    <= ST_EXPIRED;
                            r_time_up  <= 1'b1;
                            r_prof_req <= 1'b0;
                        end else if (quiz_active) begin
                            r_state    <= ST_QUIZ;
                            r_qcnt     <= QLOAD;
                            r_prof_req <= 1'b0;
                        end
                    end
                    ST_QUIZ: begin
                        if (w_expire) begin
                            r_state   <= ST_EXPIRED;
                            r_time_up <= 1'b1;
                        end else begin
                            // qcnt parks at zero so the timeout fires only once per quiz
                            if (w_tick && (r_qcnt != '0)) begin
                                r_qcnt <= r_qcnt - 1'b1;
                                if (r_qcnt == QW'(1)) begin
                                    r_quiz_timeout <= 1'b1;
                                end
                            end
                            if (!quiz_active) begin
                                r_state <= ST_RUN;
                                r_gap   <= w_gap_load;
                            end
                        end
                    end
                    ST_EXPIRED: begin
                    end
                    default: begin
                        r_state <= ST_STOP;
                    end
                endcase
            end
        end
    end

    assign minutes       = r_minutes;
    assign tick_min      = r_tick_min;
    assign professor_req = r_prof_req;
    assign quiz_timeout  = r_quiz_timeout;
    assign time_up       = r_time_up;

endmodule

// File: tb/tb_game_clock_scheduler.sv
// Directed bench for game_clock_scheduler with TICKS_PER_MIN=4 and seed 8'hA5.
module tb_game_clock_scheduler;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       pause;
    logic       quiz_active;
    logic [7:0] minutes;
    logic       tick_min;
    logic       professor_req;
    logic       quiz_timeout;
    logic       time_up;

    int n_checks = 0;
    int n_errors = 0;
    int qto_cnt  = 0;

    logic [7:0] m_lfsr;

    game_clock_scheduler #(
        .TICKS_PER_MIN (4),
        .MAX_TIME      (120),
        .QUIZ_WINDOW   (3),
        .MIN_GAP       (8),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Ack           (Ack),
        .pause         (pause),
        .quiz_active   (quiz_active),
        .minutes       (minutes),
        .tick_min      (tick_min),
        .professor_req (professor_req),
        .quiz_timeout  (quiz_timeout),
        .time_up       (time_up)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference LFSR: taps at stages 8,6,5,4, stepping every clock outside reset
    always @(posedge Clk or posedge Reset) begin
        if (Reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        logic       start;
        logic       pse;
        logic [7:0] e_min;
        logic       e_tick;
    } vec_t;

    vec_t tbl[19];

    function automatic logic [11:0] outs();
        return {minutes, tick_min, professor_req, quiz_timeout, time_up};
    endfunction

    function automatic logic [11:0] ev(input logic [7:0] mn, input logic t, input logic p,
                                       input logic q, input logic u);
        return {mn, t, p, q, u};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_tick(input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (quiz_timeout) qto_cnt++;
            if (tick_min) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk({nm, "_tick_timeout"}, 0, 1);
    endtask

    task automatic count_to_prof(input string nm, input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            wait_tick(nm);
            n++;
            if (professor_req) break;
        end
    endtask

    initial begin
        int g1, g2, g3, n, seen_tick;

        // Start pulse, first tick after 4 cycles, then 10 paused cycles while prescaler is at 2
        for (int i = 0; i < 19; i++) begin
            tbl[i].start  = (i == 0);
            tbl[i].pse    = (i >= 7 && i <= 16);
            tbl[i].e_min  = (i >= 18) ? 8'd2 : (i >= 4) ? 8'd1 : 8'd0;
            tbl[i].e_tick = (i == 4) || (i == 18);
        end

        Reset = 1'b1; Start = 1'b0; Ack = 1'b0; pause = 1'b0; quiz_active = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset", 32'(outs()), 32'(ev(8'd0, 0, 0, 0, 0)));

        g1 = 8 + int'(m_lfsr[3:0]);
        for (int i = 0; i < 19; i++) begin
            Start = tbl[i].start;
            pause = tbl[i].pse;
            @(negedge Clk);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(ev(tbl[i].e_min, tbl[i].e_tick, 0, 0, 0)));
        end
        Start = 1'b0;
        pause = 1'b0;

        // First visit lands on the minute equal to the Start-time gap
        count_to_prof("prof1", 30, n);
        chk("prof1_min", 32'(minutes), 32'(g1));
        chk("prof1_req", 32'(professor_req), 1);
        wait_tick("prof1_hold");
        chk("prof1_hold", 32'(outs()), 32'(ev(8'(g1 + 1), 1, 1, 0, 0)));

        @(negedge Clk);
        @(negedge Clk);
        quiz_active = 1'b1;
        @(negedge Clk);
        chk("prof1_fall", 32'(professor_req), 0);

        qto_cnt = 0;
        wait_tick("quiz_t1");
        chk("qto_t1", 32'(quiz_timeout), 0);
        wait_tick("quiz_t2");
        chk("qto_t2", 32'(quiz_timeout), 0);
        wait_tick("quiz_t3");
        chk("qto_t3", 32'(quiz_timeout), 1);
        wait_tick("quiz_t4");
        chk("qto_once", 32'(qto_cnt), 1);

        g2 = 8 + int'(m_lfsr[3:0]);
        quiz_active = 1'b0;
        qto_cnt = 0;
        count_to_prof("prof2", 30, n);
        chk("gap2", 32'(n), 32'(g2));
        chk("prof2_req", 32'(professor_req), 1);

        // Short quiz abandoned after one minute: no timeout
        quiz_active = 1'b1;
        @(negedge Clk);
        chk("prof2_fall", 32'(professor_req), 0);
        qto_cnt = 0;
        wait_tick("quiz2_t1");
        g3 = 8 + int'(m_lfsr[3:0]);
        quiz_active = 1'b0;
        count_to_prof("prof3", 30, n);
        chk("gap3", 32'(n), 32'(g3));
        chk("no_qto", 32'(qto_cnt), 0);

        // Leave the visit pending and run out the clock
        for (int i = 0; i < 700; i++) begin
            @(negedge Clk);
            if (time_up) break;
        end
        chk("expire", 32'(outs()), 32'(ev(8'd120, 1, 0, 0, 1)));
        seen_tick = 0;
        repeat (20) begin
            @(negedge Clk);
            if (tick_min) seen_tick++;
        end
        chk("expired_hold", 32'(outs()), 32'(ev(8'd120, 0, 0, 0, 1)));
        chk("expired_no_tick", 32'(seen_tick), 0);

        // Ack wins over a simultaneous Start
        Ack = 1'b1; Start = 1'b1;
        @(negedge Clk);
        chk("ack_clear", 32'(outs()), 32'(ev(8'd0, 0, 0, 0, 0)));
        Ack = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        chk("restart_entry", 32'(outs()), 32'(ev(8'd0, 0, 0, 0, 0)));
        repeat (3) @(negedge Clk);
        chk("restart_pre", 32'(outs()), 32'(ev(8'd0, 0, 0, 0, 0)));
        @(negedge Clk);
        chk("restart_tick", 32'(outs()), 32'(ev(8'd1, 1, 0, 0, 0)));

        // Asynchronous reset between edges
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset", 32'(outs()), 32'(ev(8'd0, 0, 0, 0, 0)));
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_clock_scheduler.md
# game_clock_scheduler

Game timekeeper and professor-visit scheduler for the first-person-second-row game. It owns the in-game `minutes` count and schedules professor interruptions at pseudo-random intervals. It enforces the quiz answer window and flags end of game time. It feeds `minutes`, `professor_req`, `quiz_timeout` and `time_up` to the game state machine, and takes `quiz_active` back from it.

## Interface
- `TICKS_PER_MIN`, default 100_000_000: `Clk` cycles per game minute (use 4 in simulation).
- `MAX_TIME`, default 120: minute count at which game time expires.
- `QUIZ_WINDOW`, default 3: minutes allowed per quiz.
- `MIN_GAP`, default 8: minimum minutes between professor visits.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.
- `Clk`  in  1  system clock.
- `Reset`  in  1  reset; asynchronous, active-high.
- `Start`  in  1  begin a game (level; sampled in STOP only).
- `Ack`  in  1  abandon or finish the game; returns the block to STOP from any state.
- `pause`  in  1  freezes the prescaler and all minute-based counting.
- `quiz_active`  in  1  high while the game FSM is in any QUIZ state.
- `minutes`  out  8  elapsed game minutes, saturating at `MAX_TIME`.
- `tick_min`  out  1  one-cycle pulse in the first cycle a new `minutes` value is visible.
- `professor_req`  out  1  level; professor is present, held until `quiz_active` rises.
- `quiz_timeout`  out  1  one-cycle pulse when the quiz window expires.
- `time_up`  out  1  level; `minutes == MAX_TIME`.

## Operation
- States: STOP, RUN, PROF_PENDING, QUIZ, EXPIRED.
- STOP:
  - Prescaler, `minutes`, gap and quiz counters are held at 0.
  - On `Start`: go to RUN and load `gap = MIN_GAP + lfsr[3:0]`, giving 8..23 minutes with defaults.
- RUN:
  - On each minute tick: `minutes` increments and `gap` decrements.
  - When `gap` reaches 0 on a tick: go to PROF_PENDING.
- PROF_PENDING:
  - `professor_req = 1`. `minutes` keeps counting; `gap` is frozen.
  - On `quiz_active`: go to QUIZ and load `qcnt = QUIZ_WINDOW`.
- QUIZ:
  - `minutes` keeps counting; `qcnt` decrements per tick.
  - When `qcnt` reaches 0: pulse `quiz_timeout` once, then stay in QUIZ.
  - On `quiz_active` falling: go to RUN and reload `gap` from the LFSR.
- EXPIRED:
  - Entered from RUN, PROF_PENDING or QUIZ when `minutes` reaches `MAX_TIME`.
  - `time_up = 1`, `professor_req = 0`, no further counting.
- `Ack` in any state: go to STOP with all counters cleared. `Ack` takes priority over `Start`.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle outside reset, so the gap depends on when the player pressed `Start`.
- Widths:
  - `gap` is 5 bits; `qcnt` is 2 bits minimum, sized from `QUIZ_WINDOW`.
  - Prescaler is `$clog2(TICKS_PER_MIN)` bits and wraps at `TICKS_PER_MIN-1`.
  - `minutes` never exceeds `MAX_TIME`.

## Timing
- Reset values:
  - `minutes = 0`, `tick_min = 0`, `professor_req = 0`, `quiz_timeout = 0`, `time_up = 0`.
  - Internal state = STOP, LFSR = `LFSR_SEED`.
- Internal minute strobe fires when the prescaler equals `TICKS_PER_MIN-1` and `pause` is low. On the next edge, `minutes`, `tick_min` and the state all update together; all outputs are registered.
- First tick arrives `TICKS_PER_MIN` cycles after the cycle RUN is entered.
- Tick while `pause` is high: the prescaler holds its value, so no tick is lost, only delayed.
- `professor_req` rises in the same cycle as the `tick_min` that drives `gap` to 0.
- `quiz_active` is sampled every cycle. Rise or fall moves the state at the next edge, with no minimum dwell time.
- `quiz_active` rising while in RUN (no request pending) is ignored.
- Simultaneous events:
  - Tick that reaches `MAX_TIME` and empties `gap` or `qcnt` in the same cycle: EXPIRED wins; no `professor_req` and no `quiz_timeout`.
  - `quiz_active` falling on the same cycle as `qcnt` expiry: `quiz_timeout` still pulses and the state goes to RUN.
  - `Reset` mid-game: immediate return to reset values, asynchronously.

## Structure
- Shared package `fpsr_pkg`:
  - State encoding enum and `MAX_TIME` (shared with the game FSM).
  - LFSR tap mask.
- One sub-module, `lfsr8`: free-running LFSR with seed parameter and enable, reused later for quiz question selection.
- Prescaler, counters and FSM stay in this module.

## Test plan
All scenarios use `TICKS_PER_MIN=4`, `LFSR_SEED=8'hA5`.
- Reset, then hold `Start` 1 cycle → every output 0 until the first tick; `minutes=1` and `tick_min` high exactly 4 cycles after RUN entry.
- Run with `quiz_active` tied low → `professor_req` rises on the tick where `minutes` equals the gap computed from the LFSR value at Start (MIN_GAP + lfsr[3:0]); it stays high and `minutes` keeps advancing.
- Raise `quiz_active` 2 cycles after `professor_req` → `professor_req` falls next cycle; `quiz_timeout` pulses once, exactly 3 ticks later.
- Drop `quiz_active` after 1 tick → no `quiz_timeout`; the next `professor_req` arrives 8..23 ticks later.
- Assert `pause` for 10 cycles mid-minute → the tick is delayed by exactly 10 cycles and `minutes` never skips.
- Run to `minutes=120` → `time_up=1` and counting stops; `Ack` → everything 0 next cycle; a fresh `Start` begins from 0.
